tstate: RTL and testbench

- Microcode T-state (micro-step) counter for the CPU control unit.
- Produces the current step number T, which the decoder combines with the opcode to select control words.
- Advances once per clock cycle on the falling edge of clk, wraps at the last step, and can be forced back to T0 asynchronously.

---
 rtl/tstate_if.sv | 21 ++
 rtl/tstate.sv | 71 +++++++
 tb/tb_tstate.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tstate_if.sv
// Bus between the control unit and the T-state counter.
// Carries the secondary active-low clear and the registered T-state outputs.
// Optional build macro TSTATE_ONEHOT_EN adds the one-hot T-state output.
interface tstate_if #(
  parameter int STATE_BITS = 3,
  parameter int LAST_STATE = 7
);
  logic                  reset2_bar;
  logic [STATE_BITS-1:0] T;
`ifdef TSTATE_ONEHOT_EN
  logic [LAST_STATE:0]   T_onehot;
`endif

`ifdef TSTATE_ONEHOT_EN
  modport master (output reset2_bar, input T, input T_onehot);
  modport slave  (input reset2_bar, output T, output T_onehot);
`else
  modport master (output reset2_bar, input T);
  modport slave  (input reset2_bar, output T);
`endif
endinterface

// File: rtl/tstate.sv
// Microcode T-state (micro-step) counter for the CPU control unit.
// Counts 0..LAST_STATE on falling clock edges and wraps to 0. Either reset1
// (active-high) or bus.reset2_bar (active-low) clears T to 0 asynchronously.
// T comes straight from negedge flops with async clear, so all bits switch
// together and the only non-clocked transition is the clear itself.
// Optional build macro TSTATE_ONEHOT_EN adds bus.T_onehot, a registered
// one-hot copy of T (bit i high iff T == i) that is 1 while clear is active.
module tstate #(
  parameter int STATE_BITS = 3,
  parameter int LAST_STATE = 7
) (
  input  logic     clk,
  input  logic     reset1,
  tstate_if.slave  bus
);

  localparam logic [STATE_BITS-1:0] LAST_T = STATE_BITS'(LAST_STATE);

  // Both clear sources are asynchronous and merged into one active-high clear.
  logic clear;
  assign clear = reset1 | ~bus.reset2_bar;

  logic [STATE_BITS-1:0] t_p0;
  logic [STATE_BITS-1:0] t_next;

  // Next step: increment, or wrap to 0 after the last step.
  always_comb begin
    t_next = t_p0 + 1'b1;
    if (t_p0 == LAST_T) begin
      t_next = '0;
    end
  end

  // Step register: advances on the falling edge, clear wins over the edge.
  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      t_p0 <= '0;
    end else begin
      t_p0 <= t_next;
    end
  end

  assign bus.T = t_p0;

`ifdef TSTATE_ONEHOT_EN
  logic [LAST_STATE:0] oh_p0;
  logic [LAST_STATE:0] oh_next;

  // Decode the next step so the one-hot flops update on the same edge as T.
  always_comb begin
    oh_next = '0;
    for (int i = 0; i <= LAST_STATE; i++) begin
      if (t_next == STATE_BITS'(i)) begin
        oh_next[i] = 1'b1;
      end
    end
  end

  // One-hot register: same clocking and clear as the binary step register.
  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      oh_p0 <= (LAST_STATE + 1)'(1);
    end else begin
      oh_p0 <= oh_next;
    end
  end

  assign bus.T_onehot = oh_p0;
`endif

endmodule

// File: tb/tb_tstate.sv
// Directed bench for the T-state counter: default instance (0..7) and a
// short-cycle instance (LAST_STATE=3); one-hot checks when TSTATE_ONEHOT_EN
// is defined.
module tb_tstate;

  logic clk;
  logic reset1_a;
  logic reset1_b;

  tstate_if #(.STATE_BITS(3), .LAST_STATE(7)) bus_a ();
  tstate_if #(.STATE_BITS(3), .LAST_STATE(3)) bus_b ();

  tstate #(.STATE_BITS(3), .LAST_STATE(7)) dut_a (
    .clk    (clk),
    .reset1 (reset1_a),
    .bus    (bus_a.slave)
  );

  tstate #(.STATE_BITS(3), .LAST_STATE(3)) dut_b (
    .clk    (clk),
    .reset1 (reset1_b),
    .bus    (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Falling edge, then wait 1 unit before the caller samples.
  task automatic fall();
    #4 clk = 1'b0;
    #1;
  endtask

  // Rising edge, then wait 1 unit.
  task automatic rise();
    #4 clk = 1'b1;
    #1;
  endtask

  initial begin
    clk              = 1'b1;
    reset1_a         = 1'b1;
    reset1_b         = 1'b1;
    bus_a.reset2_bar = 1'b1;
    bus_b.reset2_bar = 1'b1;
    #1;
    chk("reset_a", 32'(bus_a.T), 32'd0);
    chk("reset_b", 32'(bus_b.T), 32'd0);
`ifdef TSTATE_ONEHOT_EN
    chk("reset_oh", 32'(bus_b.T_onehot), 32'h1);
`endif

    // Count sequence 1..7; rising edges must not move T.
    reset1_a = 1'b0;
    #2;
    for (int i = 1; i <= 7; i++) begin
      fall();
      chk($sformatf("count_%0d", i), 32'(bus_a.T), 32'(i));
      rise();
      chk($sformatf("rise_hold_%0d", i), 32'(bus_a.T), 32'(i));
    end
    chk("held_b", 32'(bus_b.T), 32'd0);

    // Wrap 7 -> 0, then two more edges -> 2.
    fall();
    chk("wrap", 32'(bus_a.T), 32'd0);
    rise();
    fall();
    rise();
    fall();
    chk("after_wrap", 32'(bus_a.T), 32'd2);
    rise();

    // Async clear mid-count with clk static high.
    #2 reset1_a = 1'b1;
    #1;
    chk("async_clr", 32'(bus_a.T), 32'd0);
    fall();
    chk("clr_hold_fall", 32'(bus_a.T), 32'd0);
    rise();
    fall();
    chk("clr_hold_fall2", 32'(bus_a.T), 32'd0);
    rise();
    #2 reset1_a = 1'b0;
    fall();
    chk("clr_release", 32'(bus_a.T), 32'd1);
    rise();

    // Advance to 5, then secondary clear.
    for (int i = 2; i <= 5; i++) begin
      fall();
      rise();
    end
    chk("at_five", 32'(bus_a.T), 32'd5);
    #2 bus_a.reset2_bar = 1'b0;
    #1;
    chk("clr2_async", 32'(bus_a.T), 32'd0);
    fall();
    chk("clr2_hold", 32'(bus_a.T), 32'd0);
    rise();
    #2 bus_a.reset2_bar = 1'b1;
    fall();
    chk("clr2_release", 32'(bus_a.T), 32'd1);
    rise();

    // Clear and falling edge at the same instant: clear wins.
    #4;
    reset1_a = 1'b1;
    clk      = 1'b0;
    #1;
    chk("clr_vs_edge", 32'(bus_a.T), 32'd0);
    rise();
    reset1_a = 1'b0;

    // Short-cycle instance: 1,2,3,0 and matching one-hot.
    #2 reset1_b = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      fall();
      chk($sformatf("short_%0d", i), 32'(bus_b.T), 32'(i % 4));
`ifdef TSTATE_ONEHOT_EN
      chk($sformatf("onehot_%0d", i), 32'(bus_b.T_onehot), 32'(1 << (i % 4)));
`endif
      rise();
    end
    fall();
    chk("short_again", 32'(bus_b.T), 32'd1);
    rise();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
